// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle sequencer and its datapath:
// instruction fields and ALU flags toward the sequencer, select/enable lines and debug state back.
interface mc_control_fsm_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       Overflow;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       MDRWrite;
  logic       ABWrite;
  logic       ALUOutWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcBControl;
  logic [2:0] ALUControl;
  logic [1:0] PCSource;
  logic       EPCWrite;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero, Overflow,
    output PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite, ABWrite,
           ALUOutWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcBControl,
           ALUControl, PCSource, EPCWrite, State
  );

  modport slave (
    output Opcode, Funct, Zero, Overflow,
    input  PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite, ABWrite,
           ALUOutWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcBControl,
           ALUControl, PCSource, EPCWrite, State
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control sequencer (Moore, outputs registered from the next state).
// Optional macro OVERFLOW_TRAP_EN: signed overflow in R-type add/sub or addi execute diverts to TRAP.
module mc_control_fsm #(
  parameter logic [1:0] VEC_SEL = 2'b11
) (
  input  logic             clk,
  input  logic             reset_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_LW_WB     = 4'd5,
    S_SW_WRITE  = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       epc_write;
  } ctrl_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_IMM   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_REGB  = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   trap_r_s, trap_i_s;
  logic   unused_inputs_s;

  function automatic logic funct_known(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_known = 1'b1;
      default:                               funct_known = 1'b0;
    endcase
  endfunction

  // Unknown funct falls back to add so the ALU still sees a defined operation.
  function automatic logic [2:0] funct_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_ctrl = ALU_ADD; c.pc_write = 1'b1;
      end
      S_DECODE: begin
        c.ab_write = 1'b1; c.aluout_write = 1'b1; c.alu_src_b = SRCB_IMMSH; c.alu_ctrl = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_ctrl = ALU_ADD; c.aluout_write = 1'b1;
      end
      S_MEM_READ: begin
        c.iord = 1'b1; c.mdr_write = 1'b1;
      end
      S_LW_WB: begin
        c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
      end
      S_SW_WRITE: begin
        c.iord = 1'b1; c.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REGB; c.aluout_write = 1'b1;
        c.alu_ctrl = funct_alu(funct);
      end
      S_R_WB: begin
        c.reg_dst = 1'b1; c.reg_write = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REGB; c.alu_ctrl = ALU_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP: begin
        c.pc_write = 1'b1; c.pc_source = 2'b10;
      end
`ifdef OVERFLOW_TRAP_EN
      // PC already advanced by 4 in FETCH, so PC-4 recovers the faulting instruction.
      S_TRAP: begin
        c.alu_src_b = SRCB_FOUR; c.alu_ctrl = ALU_SUB; c.epc_write = 1'b1;
        c.pc_source = VEC_SEL; c.pc_write = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef OVERFLOW_TRAP_EN
  assign trap_r_s = bus.Overflow && ((bus.Funct == FN_ADD) || (bus.Funct == FN_SUB));
  assign trap_i_s = bus.Overflow;
`else
  assign trap_r_s = 1'b0;
  assign trap_i_s = 1'b0;
`endif

  assign unused_inputs_s = ^{bus.Zero, bus.Overflow, VEC_SEL};

  // Next-state selection and the control word that state will present.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.Opcode == OP_SW) begin
          state_d = S_SW_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: state_d = S_LW_WB;
      S_R_EXEC: begin
        if (!funct_known(bus.Funct)) begin
          state_d = S_FETCH;
        end else if (trap_r_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_ADDI_EXEC: begin
        if (trap_i_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_ADDI_WB;
        end
      end
      default: state_d = S_FETCH;
    endcase
    ctrl_d = decode_ctrl(state_d, bus.Funct);
  end

  // State and control-word registers; reset forces every output low at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.PCWrite        = ctrl_q.pc_write;
  assign bus.PCWriteCond    = ctrl_q.pc_write_cond;
  assign bus.IorD           = ctrl_q.iord;
  assign bus.MemWrite       = ctrl_q.mem_write;
  assign bus.IRWrite        = ctrl_q.ir_write;
  assign bus.MDRWrite       = ctrl_q.mdr_write;
  assign bus.ABWrite        = ctrl_q.ab_write;
  assign bus.ALUOutWrite    = ctrl_q.aluout_write;
  assign bus.RegDst         = ctrl_q.reg_dst;
  assign bus.MemToReg       = ctrl_q.mem_to_reg;
  assign bus.RegWrite       = ctrl_q.reg_write;
  assign bus.ALUSrcA        = ctrl_q.alu_src_a;
  assign bus.ALUSrcBControl = ctrl_q.alu_src_b;
  assign bus.ALUControl     = ctrl_q.alu_ctrl;
  assign bus.PCSource       = ctrl_q.pc_source;
  assign bus.EPCWrite       = ctrl_q.epc_write;
  assign bus.State          = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a per-instruction state-sequence model feeds expected
// (state, control word) entries; a negedge monitor pops and compares every cycle.
module tb_mc_control_fsm;
  logic clk;
  logic reset_n;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic pcw, pcwc, iord, memw, irw, mdrw, abw, aluow, regdst, memtoreg, regw, srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       epcw;
  } cw_t;

  typedef struct packed {
    logic [3:0] st;
    cw_t        cw;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ovf;
  } instr_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     seq[$];
  instr_t prog[$];
  int     n_cmp = 0;
  int     n_err = 0;
  logic   mon_en = 1'b0;

  function automatic cw_t dut_word();
    cw_t w;
    w.pcw = bus.PCWrite;   w.pcwc = bus.PCWriteCond; w.iord = bus.IorD;
    w.memw = bus.MemWrite; w.irw = bus.IRWrite;      w.mdrw = bus.MDRWrite;
    w.abw = bus.ABWrite;   w.aluow = bus.ALUOutWrite; w.regdst = bus.RegDst;
    w.memtoreg = bus.MemToReg; w.regw = bus.RegWrite; w.srca = bus.ALUSrcA;
    w.srcb = bus.ALUSrcBControl; w.aluc = bus.ALUControl; w.pcsrc = bus.PCSource;
    w.epcw = bus.EPCWrite;
    return w;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    logic [2:0] a;
    a = 3'b010;
    if (fn == 6'h22) a = 3'b110;
    if (fn == 6'h24) a = 3'b000;
    if (fn == 6'h25) a = 3'b001;
    if (fn == 6'h2A) a = 3'b111;
    return a;
  endfunction

  function automatic bit r_known(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  // Control word each state must show, straight from the state table.
  function automatic cw_t spec_word(input int st, input logic [5:0] fn);
    cw_t w;
    w = '0;
    case (st)
      1:  begin w.irw = 1'b1; w.srcb = 2'b01; w.aluc = 3'b010; w.pcw = 1'b1; end
      2:  begin w.abw = 1'b1; w.aluow = 1'b1; w.srcb = 2'b11; w.aluc = 3'b010; end
      3:  begin w.srca = 1'b1; w.srcb = 2'b00; w.aluc = 3'b010; w.aluow = 1'b1; end
      4:  begin w.iord = 1'b1; w.mdrw = 1'b1; end
      5:  begin w.memtoreg = 1'b1; w.regw = 1'b1; end
      6:  begin w.iord = 1'b1; w.memw = 1'b1; end
      7:  begin w.srca = 1'b1; w.srcb = 2'b10; w.aluow = 1'b1; w.aluc = r_alu(fn); end
      8:  begin w.regdst = 1'b1; w.regw = 1'b1; end
      9:  begin w.srca = 1'b1; w.srcb = 2'b00; w.aluc = 3'b010; w.aluow = 1'b1; end
      10: begin w.regw = 1'b1; end
      11: begin w.srca = 1'b1; w.srcb = 2'b10; w.aluc = 3'b110; w.pcwc = 1'b1; w.pcsrc = 2'b01; end
      12: begin w.pcw = 1'b1; w.pcsrc = 2'b10; end
      13: begin w.srcb = 2'b01; w.aluc = 3'b110; w.epcw = 1'b1; w.pcsrc = 2'b11; w.pcw = 1'b1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  // States visited by one instruction, starting with its FETCH.
  function automatic void build_seq(input instr_t in);
    seq.delete();
    seq.push_back(1);
    seq.push_back(2);
    case (in.op)
      6'h00: begin
        seq.push_back(7);
        if (r_known(in.fn)) begin
          if (TRAP_EN && in.ovf && (in.fn == 6'h20 || in.fn == 6'h22)) seq.push_back(13);
          else seq.push_back(8);
        end
      end
      6'h08: begin
        seq.push_back(9);
        seq.push_back((TRAP_EN && in.ovf) ? 13 : 10);
      end
      6'h23: begin seq.push_back(3); seq.push_back(4); seq.push_back(5); end
      6'h2B: begin seq.push_back(3); seq.push_back(6); end
      6'h04: seq.push_back(11);
      6'h02: seq.push_back(12);
      default: ;
    endcase
  endfunction

  function automatic void push_exp(input int st, input logic [5:0] fn);
    exp_t e;
    e.st = st[3:0];
    e.cw = spec_word(st, fn);
    sb_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: DUT state %0d with no expected entry", bus.State);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.State !== mon_e.st || dut_word() !== mon_e.cw) begin
          n_err++;
          $display("FAIL step: got state %0d ctrl %h, expected state %0d ctrl %h",
                   bus.State, dut_word(), mon_e.st, mon_e.cw);
        end
      end
    end
  end

  initial begin
    instr_t in;
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    bit found;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

    reset_n = 1'b0;
    bus.Opcode = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.Overflow = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_state", {28'd0, bus.State}, 32'd0);
      check("reset_ctrl", {12'd0, dut_word()}, 32'd0);
    end

    prog.push_back('{op: 6'h00, fn: 6'h22, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h23, fn: 6'h00, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h2B, fn: 6'h00, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h04, fn: 6'h00, z: 1'b1, ovf: 1'b0});
    prog.push_back('{op: 6'h04, fn: 6'h00, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h02, fn: 6'h00, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h3F, fn: 6'h00, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h00, fn: 6'h3F, z: 1'b0, ovf: 1'b0});
    prog.push_back('{op: 6'h08, fn: 6'h00, z: 1'b0, ovf: 1'b1});
    prog.push_back('{op: 6'h00, fn: 6'h20, z: 1'b0, ovf: 1'b1});
    prog.push_back('{op: 6'h00, fn: 6'h24, z: 1'b0, ovf: 1'b1});
    for (int i = 0; i < 150; i++) begin
      in.op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
      in.fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
      in.z   = 1'($urandom_range(0, 1));
      in.ovf = ($urandom_range(0, 3) == 0);
      prog.push_back(in);
    end

    reset_n = 1'b1;
    #1;
    push_exp(1, 6'h00);
    mon_en = 1'b1;
    @(negedge clk);
    foreach (prog[i]) begin
      bus.Opcode = prog[i].op; bus.Funct = prog[i].fn;
      bus.Zero = prog[i].z;    bus.Overflow = prog[i].ovf;
      build_seq(prog[i]);
      for (int k = 1; k < seq.size(); k++) push_exp(seq[k], prog[i].fn);
      push_exp(1, 6'h00);
      repeat (seq.size()) @(negedge clk);
    end
    #1;
    mon_en = 1'b0;
    check("sb_drained", sb_q.size(), 32'd0);

    // Asynchronous reset in the middle of a load.
    bus.Opcode = 6'h23; bus.Funct = 6'h00; bus.Overflow = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (bus.State == 4'd4) found = 1'b1;
    end
    check("reach_mem_read", {31'd0, found}, 32'd1);
    check("mdr_before_reset", {31'd0, bus.MDRWrite}, {31'd0, found});
    reset_n = 1'b0;
    #1;
    check("async_reset_state", {28'd0, bus.State}, 32'd0);
    check("async_reset_mdr", {31'd0, bus.MDRWrite}, 32'd0);
    check("async_reset_ctrl", {12'd0, dut_word()}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
